// File: rtl/alu_types.sv
// Shared ALU operation encoding used by the ALU and every block that issues ALU work.
package alu_types_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_control_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: wrapping add/sub with signed overflow, zero and equality flags.
module alu
  import alu_types_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  alu_control_t  control,
  output logic [N-1:0]  result,
  output logic          overflow,
  output logic          zero,
  output logic          equal
);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
    zero  = (result == '0);
    equal = (a == b);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ valid/ready requesters,
// one transaction in flight, result held until the granted requester accepts it.
module alu_arbiter
  import alu_types_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned N_REQ = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][N-1:0]       req_a,
  input  logic [N_REQ-1:0][N-1:0]       req_b,
  input  alu_control_t [N_REQ-1:0]      req_control,
  output logic [N_REQ-1:0]              rsp_valid,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [N-1:0]                  rsp_result,
  output logic                          rsp_overflow,
  output logic                          rsp_zero,
  output logic                          rsp_equal,
  output logic                          busy
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             r_state, w_next;
  logic [GW-1:0]      r_last_grant, r_grant_id, w_winner;
  logic               w_found, w_accept;
  logic [N-1:0]       r_op_a, r_op_b;
  alu_control_t       r_op_ctl;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [N-1:0]       r_result, w_alu_result;
  logic               r_ovf, r_zero, r_eq;
  logic               w_alu_ovf, w_alu_zero, w_alu_eq;

  alu #(.N(N)) u_alu (
    .a        (r_op_a),
    .b        (r_op_b),
    .control  (r_op_ctl),
    .result   (w_alu_result),
    .overflow (w_alu_ovf),
    .zero     (w_alu_zero),
    .equal    (w_alu_eq)
  );

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    idx      = 0;
    cand     = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx  = (32'(r_last_grant) + k) % N_REQ;
      cand = GW'(idx);
      if (!w_found && req_valid[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found && !rst) begin
          req_ready[w_winner] = 1'b1;
          w_accept            = 1'b1;
          w_next              = EXEC;
        end
      end
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready[r_grant_id]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GW'(N_REQ - 1);
      r_grant_id   <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctl     <= ALU_AND;
      r_rsp_valid  <= '0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_zero       <= 1'b0;
      r_eq         <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a       <= req_a[w_winner];
            r_op_b       <= req_b[w_winner];
            r_op_ctl     <= req_control[w_winner];
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        EXEC: begin
          r_result    <= w_alu_result;
          r_ovf       <= w_alu_ovf;
          r_zero      <= w_alu_zero;
          r_eq        <= w_alu_eq;
          r_rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;
        end
        RESP: begin
          if (rsp_ready[r_grant_id]) r_rsp_valid <= '0;
        end
        default: r_rsp_valid <= '0;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_result;
  assign rsp_overflow = r_ovf;
  assign rsp_zero     = r_zero;
  assign rsp_equal    = r_eq;
  assign busy         = (r_state != IDLE);

endmodule
